lfsr_word_gen: RTL and testbench
================================

LFSR_WORD_GEN -- requirements
Module: lfsr_word_gen

Interface
REQ-001 Parameter N, default 32, LFSR state width, 2..64.
REQ-002 Parameter W, default 8, keystream output word width, 1..N.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  step enable; the LFSR advances only in FILL with en=1.
REQ-006 ld  input  1  load seed; priority over en.
REQ-007 mode  input  1  0 = Galois step, 1 = Fibonacci step; sampled every step.
REQ-008 taps  input  N  feedback polynomial mask, bit i = tap at stage i.
REQ-009 seed  input  N  value loaded on ld.
REQ-010 o_data  output  W  assembled keystream word.
REQ-011 o_valid  output  1  o_data holds a complete word.
REQ-012 o_ready  input  1  consumer accepts the word when o_valid=1.
REQ-013 state_o  output  N  current LFSR state.
REQ-014 seed_err  output  1  one-cycle pulse: a zero seed was rejected.

Function
REQ-015 Two states: FILL (collecting bits, o_valid=0) and HOLD (word complete, o_valid=1).
REQ-016 Output bit k = lfsr[N-1], taken before the step in which it is produced.
REQ-017 Galois step: lfsr <= {lfsr[N-2:0],0} XOR (taps AND {N{lfsr[N-1]}}).
REQ-018 Fibonacci step: lfsr <= {lfsr[N-2:0], XOR-reduce(lfsr AND taps)}.
REQ-019 FILL with en=1 and ld=0: LFSR steps once, word <= {word[W-2:0],k} (first bit ends up in o_data[W-1]), cnt increments.
REQ-020 FILL with en=0: LFSR, word and cnt hold.
REQ-021 When the W-th bit is shifted in, the next cycle is HOLD, o_valid=1, cnt=0; latency = exactly W enabled cycles per word.
REQ-022 HOLD: LFSR and o_data frozen regardless of en; o_data stable while o_valid=1 and o_ready=0.
REQ-023 HOLD with o_ready=1: word accepted; next cycle FILL, o_valid=0; the LFSR does not step in the handshake cycle.
REQ-024 ld=1 in any state: lfsr <= seed, cnt <= 0, word <= 0, state <= FILL, o_valid <= 0; any pending word is discarded even if o_ready=1 in the same cycle.
REQ-025 ld=1 with seed=0: lfsr <= all-ones instead, and seed_err=1 for the next cycle only; otherwise seed_err=0.
REQ-026 ld and en in the same cycle: the load wins and no step occurs.
REQ-027 A zero taps mask is legal; behaviour follows REQ-017/018 as written, with no error flag.
REQ-028 state_o = lfsr at all times (registered, no combinational path from inputs).
REQ-029 cnt width = clog2(W+1); cnt never exceeds W-1 in FILL.

Reset
REQ-030 rst has priority over ld and en.
REQ-031 On rst: lfsr = all-ones, word = 0 (o_data = 0), cnt = 0, state = FILL, o_valid = 0, seed_err = 0.
REQ-032 rst mid-word or in HOLD discards all partial or pending data; no residue from before reset may reach o_data.

Verification
REQ-033 N=8, W=4, Galois, taps=0x1D, after reset, en=1, o_ready=0 -> states 0xE3, 0xDB, 0xAB, 0x4B; o_valid rises 4 cycles after en, o_data=4'b1111, state_o held at 0x4B.
REQ-034 Same configuration, hold o_ready=0 for 10 cycles and then pulse it -> o_data and state_o are constant throughout; o_valid drops the cycle after acceptance, and the next word completes 4 en cycles later.
REQ-035 N=8, Fibonacci, taps=0x1D, state 0xFF, en=1 -> next state 0xFE, first output bit 1.
REQ-036 ld=1, seed=0x00 -> state_o=0xFF next cycle and seed_err high for exactly one cycle; ld with seed=0x5A -> state_o=0x5A, no seed_err.
REQ-037 ld asserted in HOLD with o_ready=1 -> word not counted as accepted, o_valid=0 next cycle, state FILL, cnt=0.
REQ-038 rst asserted after 2 of 4 bits with en=1 and ld=1 -> state_o=0xFF, o_valid=0, and the next word equals the first word after a clean reset (4'b1111).

Source files
------------

// File: rtl/lfsr_word_gen.sv
// Keystream word generator: a Galois/Fibonacci LFSR whose output bits are
// packed MSB-first into W-bit words and handed out with a valid/ready handshake.
module lfsr_word_gen #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         ld,
  input  logic         mode,
  input  logic [N-1:0] taps,
  input  logic [N-1:0] seed,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] state_o,
  output logic         seed_err
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  lfsr_q, lfsr_d;
  logic [W-1:0]  word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          seed_err_q, seed_err_d;

  logic          out_bit;
  logic [N-1:0]  galois_next;
  logic [N-1:0]  fib_next;
  logic [N-1:0]  step_next;

  // The keystream bit is the MSB as it stands before the step.
  assign out_bit     = lfsr_q[N-1];
  assign galois_next = {lfsr_q[N-2:0], 1'b0} ^ (taps & {N{out_bit}});
  assign fib_next    = {lfsr_q[N-2:0], ^(lfsr_q & taps)};
  assign step_next   = mode ? fib_next : galois_next;

  // NOTE: every signal gets its hold value before any branch, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    seed_err_d = 1'b0;

    if (ld) begin
      // A zero seed would lock the LFSR at zero forever; substitute all-ones.
      lfsr_d     = (seed == '0) ? '1 : seed;
      seed_err_d = (seed == '0);
      word_d     = '0;
      cnt_d      = '0;
      state_d    = FILL;
    end else if (state_q == FILL) begin
      if (en) begin
        lfsr_d = step_next;
        // Shift form works for W=1 too, where word_q[W-2:0] would not exist.
        word_d = (word_q << 1) | W'(out_bit);
        if (cnt_q == CW'(W - 1)) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end else begin
      if (o_ready) begin
        state_d = FILL;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      lfsr_q     <= '1;
      word_q     <= '0;
      cnt_q      <= '0;
      seed_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      seed_err_q <= seed_err_d;
    end
  end

  assign o_data   = word_q;
  assign o_valid  = (state_q == HOLD);
  assign state_o  = lfsr_q;
  assign seed_err = seed_err_q;

endmodule

// File: tb/tb_lfsr_word_gen.sv
// Self-checking bench for lfsr_word_gen (N=8, W=4): directed scenarios followed
// by randomized traffic, all compared against an arithmetic reference model.
module tb_lfsr_word_gen;

  localparam int N = 8;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         ld = 1'b0;
  logic         mode = 1'b0;
  logic [N-1:0] taps = 8'h1D;
  logic [N-1:0] seed = 8'h00;
  logic         o_ready = 1'b0;
  logic [W-1:0] o_data;
  logic         o_valid;
  logic [N-1:0] state_o;
  logic         seed_err;

  int checks = 0;
  int errors = 0;

  // Reference model, kept as plain integers.
  int m_lfsr  = 255;
  int m_word  = 0;
  int m_bits  = 0;
  bit m_full  = 0;
  bit m_err   = 0;
  int m_words = 0;

  lfsr_word_gen #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ld       (ld),
    .mode     (mode),
    .taps     (taps),
    .seed     (seed),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .state_o  (state_o),
    .seed_err (seed_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Galois: multiply by x modulo the tap polynomial; Fibonacci: shift in the
  // parity of the tapped stages.
  function automatic int galois(input int s, input int t);
    int v;
    v = s * 2;
    if (v >= 256) v = (v - 256) ^ t;
    return v;
  endfunction

  function automatic int fibonacci(input int s, input int t);
    int par;
    par = $countones(8'(s & t)) % 2;
    return ((s * 2) % 256) + par;
  endfunction

  function automatic void model_update();
    int b;
    if (rst) begin
      m_lfsr = 255; m_word = 0; m_bits = 0; m_full = 0; m_err = 0;
    end else if (ld) begin
      m_lfsr = (seed == 0) ? 255 : int'(seed);
      m_err  = (seed == 0);
      m_word = 0; m_bits = 0; m_full = 0;
    end else begin
      m_err = 0;
      if (m_full) begin
        if (o_ready) begin
          m_full = 0;
          m_words++;
        end
      end else if (en) begin
        b      = m_lfsr / 128;
        m_lfsr = mode ? fibonacci(m_lfsr, int'(taps)) : galois(m_lfsr, int'(taps));
        m_word = (m_word * 2 + b) % 16;
        m_bits++;
        if (m_bits == W) begin
          m_full = 1;
          m_bits = 0;
        end
      end
    end
  endfunction

  // One clock: advance the model with the inputs the DUT is about to sample,
  // then compare all outputs shortly after the edge.
  task automatic cycle(input string tag);
    model_update();
    @(posedge clk);
    #1;
    check({tag, ".state"}, 64'(state_o), 64'(m_lfsr));
    check({tag, ".data"}, 64'(o_data), 64'(m_word));
    check({tag, ".valid"}, 64'(o_valid), 64'(m_full));
    check({tag, ".serr"}, 64'(seed_err), 64'(m_err));
  endtask

  logic [7:0] exp_states [4];

  initial begin
    exp_states[0] = 8'hE3; exp_states[1] = 8'hDB;
    exp_states[2] = 8'hAB; exp_states[3] = 8'h4B;

    // Reset
    rst = 1'b1;
    cycle("rst0");
    cycle("rst1");
    rst = 1'b0;
    check("reset.state", 64'(state_o), 64'h FF);
    check("reset.valid", 64'(o_valid), 64'h0);
    check("reset.data", 64'(o_data), 64'h0);

    // Galois first word: fixed sequence of states and a 4-cycle latency
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle("galois");
      check("galois.seq", 64'(state_o), 64'(exp_states[i]));
      check("galois.lat", 64'(o_valid), (i == 3) ? 64'h1 : 64'h0);
    end
    check("galois.word", 64'(o_data), 64'h F);

    // Stall in HOLD for 10 cycles with en still high
    for (int i = 0; i < 10; i++) begin
      cycle("stall");
      check("stall.state", 64'(state_o), 64'h 4B);
      check("stall.data", 64'(o_data), 64'h F);
    end

    // Accept: valid drops, no LFSR step in the handshake cycle
    o_ready = 1'b1;
    cycle("accept");
    check("accept.valid", 64'(o_valid), 64'h0);
    check("accept.state", 64'(state_o), 64'h 4B);
    o_ready = 1'b0;
    for (int i = 0; i < 4; i++) cycle("word2");
    check("word2.valid", 64'(o_valid), 64'h1);
    check("word2.data", 64'(o_data), 64'h 4);
    check("word2.state", 64'(state_o), 64'h C4);

    // Load in HOLD with o_ready=1: pending word discarded
    ld = 1'b1; seed = 8'h5A; o_ready = 1'b1;
    cycle("ldhold");
    check("ldhold.valid", 64'(o_valid), 64'h0);
    check("ldhold.state", 64'(state_o), 64'h 5A);
    check("ldhold.serr", 64'(seed_err), 64'h0);
    o_ready = 1'b0;

    // Zero seed rejected, one-cycle error pulse
    seed = 8'h00;
    cycle("ldzero");
    check("ldzero.state", 64'(state_o), 64'h FF);
    check("ldzero.serr", 64'(seed_err), 64'h1);
    ld = 1'b0; en = 1'b0;
    cycle("ldzero2");
    check("ldzero2.serr", 64'(seed_err), 64'h0);

    // Fibonacci step from all-ones
    mode = 1'b1; en = 1'b1;
    cycle("fib");
    check("fib.state", 64'(state_o), 64'h FE);
    check("fib.bit", 64'(o_data), 64'h1);
    mode = 1'b0; en = 1'b0;

    // Reset mid-word with en and ld asserted
    ld = 1'b1; seed = 8'h00;
    cycle("pre");
    ld = 1'b0; en = 1'b1;
    cycle("mid0");
    cycle("mid1");
    rst = 1'b1; ld = 1'b1; seed = 8'h5A;
    cycle("rstmid");
    check("rstmid.state", 64'(state_o), 64'h FF);
    check("rstmid.valid", 64'(o_valid), 64'h0);
    rst = 1'b0; ld = 1'b0;
    for (int i = 0; i < 4; i++) cycle("postrst");
    check("postrst.word", 64'(o_data), 64'h F);
    check("postrst.valid", 64'(o_valid), 64'h1);

    // Randomized traffic, including zero seeds and zero tap masks
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 79) == 0);
      ld      = ($urandom_range(0, 15) == 0);
      seed    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      en      = ($urandom_range(0, 3) != 0);
      o_ready = ($urandom_range(0, 2) == 0);
      mode    = 1'($urandom);
      if ($urandom_range(0, 49) == 0)
        taps = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cycle("rand");
    end
    check("rand.words_seen", 64'(m_words > 10), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
